// File: rtl/mem_bus_if.sv
// mem_bus_responder request/response bundle.
// master = CPU-side initiator, slave = memory responder.
interface mem_bus_if #(
   parameter int AW = 13,
   parameter int DW = 8
);
   logic [AW-1:0] addr;
   logic          rd;
   logic          wr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          data_oe;
   logic          ready;
   logic          wr_done;
   logic          busy;
   logic          bus_err;

   modport master (
      output addr, rd, wr, data_in,
      input  data_out, data_oe, ready,
      input  wr_done, busy, bus_err
   );

   modport slave (
      input  addr, rd, wr, data_in,
      output data_out, data_oe, ready,
      output wr_done, busy, bus_err
   );
endinterface

// File: rtl/mem_bus_responder.sv
// Wait-stated RAM responder for level-held rd/wr strobes.
// Optional write protection below ROM_TOP: define MEM_WPROT_EN.
module mem_bus_responder #(
   parameter int             AW       = 13,
   parameter int             DW       = 8,
   parameter int             WAIT_CYC = 1,
   parameter logic [AW-1:0]  ROM_TOP  = 13'h0FFF
) (
   input  logic      clk1,
   input  logic      rst,
   mem_bus_if.slave  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RWAIT = 3'd1;
   localparam logic [2:0] S_RDATA = 3'd2;
   localparam logic [2:0] S_WWAIT = 3'd3;
   localparam logic [2:0] S_WHOLD = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);
   localparam bit         ZERO_WS = (WAIT_CYC == 0);

`ifdef MEM_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];

   logic [2:0]    state;
   logic [2:0]    cnt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] dout_q;
   logic          wdone_q;
   logic          err_q;
   logic          intr_q;

   logic          rd_only;
   logic          wr_only;
   logic          both;
   logic          intr;
   logic          intr_rise;
   logic          commit;
   logic          wprot;
   logic          mem_we;
   logic          rd_fire;
   logic [AW-1:0] rd_idx;

   // Request decode, intrusion detect and commit/read strobes.
   always_comb begin
      rd_only = bus.rd & ~bus.wr;
      wr_only = bus.wr & ~bus.rd;
      both    = bus.rd & bus.wr;
      intr    = 1'b0;
      case (state)
         S_RWAIT, S_RDATA: intr = bus.wr;
         S_WWAIT, S_WHOLD: intr = bus.rd;
         default:          intr = 1'b0;
      endcase
      intr_rise = intr & ~intr_q;
      commit    = (state == S_WWAIT) & bus.wr
                & (cnt <= 3'd1);
      wprot     = WPROT & (addr_q <= ROM_TOP);
      mem_we    = commit & ~wprot;
      rd_fire   = 1'b0;
      rd_idx    = addr_q;
      if (state == S_IDLE) begin
         rd_fire = rd_only & ZERO_WS;
         rd_idx  = bus.addr;
      end else if (state == S_RWAIT) begin
         rd_fire = bus.rd & (cnt == 3'd1);
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk1) begin
      if (mem_we)
         mem[addr_q] <= bus.data_in;
   end

   // Transaction FSM, read data register and status pulses.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         addr_q  <= '0;
         dout_q  <= '0;
         wdone_q <= 1'b0;
         err_q   <= 1'b0;
         intr_q  <= 1'b0;
      end else begin
         wdone_q <= mem_we;
         err_q   <= intr_rise
                  | (commit & wprot)
                  | ((state == S_IDLE) & both);
         intr_q  <= intr;
         if (rd_fire)
            dout_q <= mem[rd_idx];
         case (state)
            S_IDLE: begin
               if (rd_only) begin
                  addr_q <= bus.addr;
                  cnt    <= WAIT_LD;
                  state  <= ZERO_WS ? S_RDATA
                                    : S_RWAIT;
               end else if (wr_only) begin
                  addr_q <= bus.addr;
                  cnt    <= WAIT_LD;
                  state  <= S_WWAIT;
               end else if (both) begin
                  state  <= S_ERR;
               end
            end
            S_RWAIT: begin
               if (cnt != 3'd0)
                  cnt <= cnt - 3'd1;
               if (!bus.rd)
                  state <= S_IDLE;
               else if (cnt == 3'd1)
                  state <= S_RDATA;
            end
            S_RDATA: begin
               if (!bus.rd)
                  state <= S_IDLE;
            end
            S_WWAIT: begin
               if (cnt != 3'd0)
                  cnt <= cnt - 3'd1;
               if (!bus.wr)
                  state <= S_IDLE;
               else if (commit)
                  state <= S_WHOLD;
            end
            S_WHOLD: begin
               if (!bus.wr)
                  state <= S_IDLE;
            end
            S_ERR: begin
               if (!bus.rd && !bus.wr)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.data_out = dout_q;
   assign bus.data_oe  = (state == S_RDATA);
   assign bus.ready    = (state == S_RDATA);
   assign bus.wr_done  = wdone_q;
   assign bus.busy     = (state != S_IDLE);
   assign bus.bus_err  = err_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a
// transaction-level memory/latency model.
module tb_mem_bus_responder;
   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   always #5 clk1 = ~clk1;

   mem_bus_if #(.AW(13), .DW(8)) b0 ();
   mem_bus_if #(.AW(13), .DW(8)) b1 ();

   mem_bus_responder #(
      .AW(13), .DW(8), .WAIT_CYC(1),
      .ROM_TOP(13'h0FFF)
   ) u0 (.clk1(clk1), .rst(rst), .bus(b0));

   mem_bus_responder #(
      .AW(13), .DW(8), .WAIT_CYC(3),
      .ROM_TOP(13'h0FFF)
   ) u1 (.clk1(clk1), .rst(rst), .bus(b1));

   logic [12:0] t_addr [2];
   logic        t_rd   [2];
   logic        t_wr   [2];
   logic [7:0]  t_din  [2];

   assign b0.addr    = t_addr[0];
   assign b0.rd      = t_rd[0];
   assign b0.wr      = t_wr[0];
   assign b0.data_in = t_din[0];
   assign b1.addr    = t_addr[1];
   assign b1.rd      = t_rd[1];
   assign b1.wr      = t_wr[1];
   assign b1.data_in = t_din[1];

   logic [7:0] o_dout [2];
   logic       o_oe   [2];
   logic       o_rdy  [2];
   logic       o_done [2];
   logic       o_busy [2];
   logic       o_err  [2];

   assign o_dout[0] = b0.data_out;
   assign o_oe[0]   = b0.data_oe;
   assign o_rdy[0]  = b0.ready;
   assign o_done[0] = b0.wr_done;
   assign o_busy[0] = b0.busy;
   assign o_err[0]  = b0.bus_err;
   assign o_dout[1] = b1.data_out;
   assign o_oe[1]   = b1.data_oe;
   assign o_rdy[1]  = b1.ready;
   assign o_done[1] = b1.wr_done;
   assign o_busy[1] = b1.busy;
   assign o_err[1]  = b1.bus_err;

   logic [7:0] mm [int];
   logic [7:0] last_dout [2];
   int pass_n  = 0;
   int total_n = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total_n++;
      if (got === exp)
         pass_n++;
      else
         $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
   endtask

   function automatic int wc(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic int wr_lat(input int u);
      return (wc(u) == 0) ? 1 : wc(u);
   endfunction

   function automatic bit prot(input logic [12:0] a);
`ifdef MEM_WPROT_EN
      return a <= 13'h0FFF;
`else
      return (a != a);
`endif
   endfunction

   function automatic int key(input int u,
                              input logic [12:0] a);
      return u * 8192 + int'(a);
   endfunction

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk_idle(input int u, input string tag);
      check({tag, "_busy"}, o_busy[u], 0);
      check({tag, "_rdy"},  o_rdy[u],  0);
      check({tag, "_oe"},   o_oe[u],   0);
   endtask

   task automatic rd_txn(input int u, input logic [12:0] a,
                         input int hold);
      logic [7:0] exp;
      exp = mm[key(u, a)];
      t_addr[u] = a;
      t_rd[u]   = 1'b1;
      tick();
      for (int n = 0; n < wc(u); n++) begin
         check("rd_wait_rdy", o_rdy[u], 0);
         check("rd_wait_busy", o_busy[u], 1);
         tick();
      end
      check("rd_rdy", o_rdy[u], 1);
      check("rd_oe", o_oe[u], 1);
      check("rd_data", o_dout[u], exp);
      for (int n = 0; n < hold; n++) begin
         t_addr[u] = 13'($urandom);
         tick();
         check("rd_hold_rdy", o_rdy[u], 1);
         check("rd_hold_data", o_dout[u], exp);
      end
      t_rd[u] = 1'b0;
      tick();
      chk_idle(u, "rd_end");
      last_dout[u] = exp;
   endtask

   task automatic wr_txn(input int u, input logic [12:0] a,
                         input logic [7:0] d, input int extra);
      bit p;
      int c;
      p = prot(a);
      c = wr_lat(u);
      t_addr[u] = a;
      t_wr[u]   = 1'b1;
      t_din[u]  = ~d;
      tick();
      for (int n = 0; n < c; n++) begin
         check("wr_wait_done", o_done[u], 0);
         check("wr_wait_busy", o_busy[u], 1);
         if (n == c - 1)
            t_din[u] = d;
         tick();
      end
      check("wr_done", o_done[u], {31'd0, !p});
      check("wr_perr", o_err[u], {31'd0, p});
      if (!p)
         mm[key(u, a)] = d;
      t_din[u] = 8'($urandom);
      for (int n = 0; n < extra; n++) begin
         tick();
         check("wr_hold_done", o_done[u], 0);
         check("wr_hold_busy", o_busy[u], 1);
      end
      t_wr[u] = 1'b0;
      tick();
      check("wr_end_busy", o_busy[u], 0);
   endtask

   task automatic abort_rd(input int u, input logic [12:0] a);
      int k;
      k = $urandom_range(wc(u) - 1, 0);
      t_addr[u] = a;
      t_rd[u]   = 1'b1;
      tick();
      for (int n = 0; n < k; n++) begin
         check("ab_rd_rdy", o_rdy[u], 0);
         tick();
      end
      t_rd[u] = 1'b0;
      tick();
      chk_idle(u, "ab_rd");
      check("ab_rd_data", o_dout[u], last_dout[u]);
   endtask

   task automatic abort_wr(input int u, input logic [12:0] a);
      int k;
      k = $urandom_range(wr_lat(u) - 1, 0);
      t_addr[u] = a;
      t_wr[u]   = 1'b1;
      t_din[u]  = 8'($urandom);
      tick();
      for (int n = 0; n < k; n++) begin
         check("ab_wr_done", o_done[u], 0);
         tick();
      end
      t_wr[u] = 1'b0;
      tick();
      check("ab_wr_busy", o_busy[u], 0);
      check("ab_wr_done2", o_done[u], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] pool [8];
      for (int u = 0; u < 2; u++) begin
         t_addr[u]    = '0;
         t_rd[u]      = 1'b0;
         t_wr[u]      = 1'b0;
         t_din[u]     = '0;
         last_dout[u] = '0;
      end
      tick();
      tick();
      for (int u = 0; u < 2; u++) begin
         chk_idle(u, "rst");
         check("rst_dout", o_dout[u], 0);
         check("rst_done", o_done[u], 0);
         check("rst_err", o_err[u], 0);
      end
      @(negedge clk1);
      rst = 1'b0;
      tick();

      wr_txn(0, 13'h1800, 8'h5A, 0);
      rd_txn(0, 13'h1800, 3);
      wr_txn(0, 13'h1801, 8'hC3, 5);
      rd_txn(0, 13'h1801, 1);

      wr_txn(1, 13'h1234, 8'h77, 1);
      t_addr[1] = 13'h1234;
      t_rd[1]   = 1'b1;
      tick();
      tick();
      t_rd[1] = 1'b0;
      tick();
      chk_idle(1, "ab1_rd");
      check("ab1_data", o_dout[1], last_dout[1]);
      abort_wr(1, 13'h1234);
      rd_txn(1, 13'h1234, 0);

      t_rd[0] = 1'b1;
      t_wr[0] = 1'b1;
      tick();
      check("both_err", o_err[0], 1);
      check("both_busy", o_busy[0], 1);
      tick();
      check("both_err2", o_err[0], 0);
      t_rd[0] = 1'b0;
      tick();
      check("both_busy2", o_busy[0], 1);
      t_wr[0] = 1'b0;
      tick();
      check("both_idle", o_busy[0], 0);

      t_addr[0] = 13'h1800;
      t_rd[0]   = 1'b1;
      tick();
      tick();
      check("intr_rdy0", o_rdy[0], 1);
      t_wr[0] = 1'b1;
      tick();
      check("intr_err", o_err[0], 1);
      check("intr_rdy", o_rdy[0], 1);
      check("intr_data", o_dout[0], 8'h5A);
      tick();
      check("intr_err2", o_err[0], 0);
      check("intr_rdy2", o_rdy[0], 1);
      t_wr[0] = 1'b0;
      tick();
      t_rd[0] = 1'b0;
      tick();
      chk_idle(0, "intr_end");
      check("intr_done", o_done[0], 0);
      last_dout[0] = 8'h5A;

      t_addr[1] = 13'h1234;
      t_din[1]  = 8'hEE;
      t_wr[1]   = 1'b1;
      tick();
      tick();
      tick();
      check("rstw_busy0", o_busy[1], 1);
      #1 rst = 1'b1;
      #1;
      chk_idle(1, "rstw");
      check("rstw_dout", o_dout[1], 0);
      check("rstw_done", o_done[1], 0);
      check("rstw_err", o_err[1], 0);
      t_wr[1] = 1'b0;
      last_dout[0] = '0;
      last_dout[1] = '0;
      @(negedge clk1);
      rst = 1'b0;
      tick();
      rd_txn(1, 13'h1234, 0);

      wr_txn(0, 13'h0010, 8'hFF, 1);
      if (!prot(13'h0010))
         rd_txn(0, 13'h0010, 0);
      wr_txn(0, 13'h1000, 8'hA5, 0);
      rd_txn(0, 13'h1000, 0);

      for (int i = 0; i < 8; i++)
         pool[i] = 13'($urandom);
      for (int i = 0; i < 60; i++) begin
         int u;
         int op;
         logic [12:0] a;
         u  = $urandom_range(1, 0);
         op = $urandom_range(3, 0);
         a  = pool[$urandom_range(7, 0)];
         case (op)
            0: begin
               if (mm.exists(key(u, a)))
                  rd_txn(u, a, $urandom_range(2, 0));
               else
                  wr_txn(u, a, 8'($urandom), 0);
            end
            1: wr_txn(u, a, 8'($urandom),
                      $urandom_range(2, 0));
            2: abort_rd(u, a);
            default: abort_wr(u, a);
         endcase
      end

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
